// File: rtl/hack_mem_pkg.sv
// Shared defaults, requester IDs and a width helper for the Hack data-RAM arbiter.
// Optional feature macro used by the arbiter: HACK_ARB_STARVE_GUARD_EN.
package hack_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 15;
   localparam int unsigned DATA_W_DEF = 16;

   localparam int unsigned REQ_CPU_W = 0;
   localparam int unsigned REQ_CPU_R = 1;
   localparam int unsigned REQ_DMA   = 2;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/hack_arb_prio.sv
// Masked lowest-index priority encoder: starved requesters win over plain ones.
// Used by hack_mem_arbiter (starvation mask is all-zero unless HACK_ARB_STARVE_GUARD_EN).
module hack_arb_prio
   import hack_mem_pkg::*;
#(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [N-1:0]     starved_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   logic [N-1:0] masked;
   logic [N-1:0] cand;

   always_comb begin
      masked  = req_i & starved_i;
      cand    = (|masked) ? masked : req_i;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = |cand;
      // Scan downwards so the lowest set index is the last (winning) assignment.
      for (int unsigned k = 0; k < N; k++) begin
         if (cand[N-1-k]) begin
            gnt_o          = '0;
            gnt_o[N-1-k]   = 1'b1;
            idx_o          = IDX_W'(N-1-k);
         end
      end
   end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Fixed-priority arbiter sharing one single-port data RAM between N_REQ masters.
// Define HACK_ARB_STARVE_GUARD_EN to enable per-requester wait counters (MAX_WAIT promotion).
module hack_mem_arbiter
   import hack_mem_pkg::*;
#(
   parameter int unsigned N_REQ    = 3,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned MAX_WAIT = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_we,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          gnt,
   output logic                      rvalid,
   output logic [clog2(N_REQ)-1:0]   rid,
   output logic [DATA_W-1:0]         rdata,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int unsigned ID_W = clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
      $error("hack_mem_arbiter: N_REQ must be 2..8");
   end
   if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
      $error("hack_mem_arbiter: MAX_WAIT must be 1..255");
   end

   logic [N_REQ-1:0] req_act;
   logic [N_REQ-1:0] starved;
   logic [ID_W-1:0]  gnt_idx;
   logic             any_gnt;

   // Reset is asynchronous, so the combinational grant path must be gated too.
   assign req_act = rst ? '0 : req;

`ifdef HACK_ARB_STARVE_GUARD_EN
   logic [7:0] wait_q [N_REQ];
   logic [7:0] wait_d [N_REQ];

   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         starved[i] = req_act[i] && (wait_q[i] >= 8'(MAX_WAIT));
         if (!req_act[i] || gnt[i]) begin
            wait_d[i] = '0;
         end else if (wait_q[i] < 8'(MAX_WAIT)) begin
            wait_d[i] = wait_q[i] + 8'd1;
         end else begin
            wait_d[i] = wait_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_REQ; i++) wait_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N_REQ; i++) wait_q[i] <= wait_d[i];
      end
   end
`else
   assign starved = '0;
`endif

   hack_arb_prio #(
      .N     (N_REQ),
      .IDX_W (ID_W)
   ) u_prio (
      .req_i     (req_act),
      .starved_i (starved),
      .gnt_o     (gnt),
      .idx_o     (gnt_idx),
      .valid_o   (any_gnt)
   );

   always_comb begin
      mem_en    = any_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            mem_we    = req_we[i];
            mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   logic            pend_rd_q, pend_rd_d;
   logic [ID_W-1:0] pend_id_q, pend_id_d;

   always_comb begin
      pend_rd_d = any_gnt & ~mem_we;
      pend_id_d = pend_rd_d ? gnt_idx : pend_id_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_rd_q <= 1'b0;
         pend_id_q <= '0;
      end else begin
         pend_rd_q <= pend_rd_d;
         pend_id_q <= pend_id_d;
      end
   end

   assign rvalid = pend_rd_q;
   assign rid    = pend_id_q;
   assign rdata  = mem_rdata;

endmodule

// File: doc/hack_mem_arbiter.md
Name: hack_mem_arbiter

Overview:
- Shares one single-port synchronous data RAM (1-cycle read latency) between N_REQ requesters.
- Default requesters: CPU data write (0), CPU data read (1), screen/DMA engine (2).
- Grants at most one access per clock using fixed priority (lowest index wins) plus a starvation guard.
- Returns read data tagged with the requester ID; sits between the Hack CPU/DMA masters and the data RAM.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ADDR_W, 15, RAM word-address width.
- DATA_W, 16, data width.
- MAX_WAIT, 7, cycles a pending request may lose arbitration before it is promoted (1..255).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  request per requester; level, held until granted.
- req_we  in  N_REQ  per-requester write enable (1 = write, 0 = read).
- req_addr  in  N_REQ*ADDR_W  flattened addresses; slice i = requester i.
- req_wdata  in  N_REQ*DATA_W  flattened write data.
- gnt  out  N_REQ  one-hot, one-cycle pulse; the access issues this cycle.
- rvalid  out  1  read data valid, exactly 1 cycle after a read grant.
- rid  out  $clog2(N_REQ)  requester index owning rdata.
- rdata  out  DATA_W  read data (copy of mem_rdata).
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en & !mem_we.

Behaviour:
- Reset values: gnt=0, rvalid=0, rid=0, all wait counters=0, pend_rd=0.
- gnt, mem_en, mem_we, mem_addr and mem_wdata are combinational from req, the counters and the input slices.
- rvalid, rid and rdata path: rvalid and rid are registered; rdata is driven directly from mem_rdata.
- Arbitration each cycle:
  - Starved set = {i : req[i] & wait[i] >= MAX_WAIT}.
  - If the starved set is non-empty, grant its lowest index; otherwise grant the lowest index among req.
  - req == 0 gives gnt = 0 and mem_en = 0.
- On grant of i:
  - mem_en = 1, mem_we = req_we[i], mem_addr = slice i, mem_wdata = slice i.
  - A write completes at the edge.
  - A read sets pend_rd = 1 and pend_id = i; the next cycle gives rvalid = 1 and rid = pend_id.
- Wait counters, per requester:
  - Cleared when granted or when req[i] = 0.
  - Incremented when req[i] & !gnt[i].
  - Saturate at MAX_WAIT.
- Back-to-back reads are allowed; with one read granted per cycle, rvalid can stay high continuously.
- Requester contract: addr, we and wdata are stable while req is high; req may drop only after gnt.
- Deasserting req before gnt is tolerated: no access occurs and the counter clears.
- Simultaneous starvation of several requesters: the lowest index wins, the others keep their saturated count.
- A read and a write to the same address in consecutive cycles are strictly ordered by grant order. RAM semantics apply; there is no forwarding.
- Reset mid-read: the pending rvalid is discarded and never emitted.

Optional Feature:
- Macro: HACK_ARB_STARVE_GUARD_EN.
- Defined: starvation guard active as described above.
- Undefined:
  - Pure fixed priority; wait counters and MAX_WAIT logic are not synthesized.
  - The parameter remains but is ignored.
  - A low-priority requester may starve indefinitely.

Decomposition:
- Package hack_mem_pkg holds:
  - ADDR_W and DATA_W defaults.
  - Requester ID constants REQ_CPU_W=0, REQ_CPU_R=1, REQ_DMA=2.
  - ID width function clog2.
- One sub-module, hack_arb_prio: combinational masked lowest-index priority encoder.
  - Inputs: req, starved mask.
  - Outputs: one-hot gnt and encoded index.
  - Instantiated once.

Test Plan:
- Single read: req=3'b010, addr1=0x0010, RAM[0x10]=0xBEEF → gnt=3'b010 at cycle 0; rvalid=1, rid=1, rdata=0xBEEF at cycle 1.
- Write then read same address: req0 writes 0x1234 to 0x0020, next cycle req1 reads 0x0020 → rdata=0x1234, rid=1.
- Contention: req=3'b111 held, all reads → grant order 0,1,2 with rid following one cycle later.
- Starvation (guard on, MAX_WAIT=7): req0 continuously re-requesting, req2 held → req2 granted on cycle 7, then the counter clears.
- Same stimulus with the guard off → req2 never granted over 100 cycles.
- Async reset asserted mid-cycle between a read grant and rvalid → rvalid stays 0, gnt=0 immediately; after release, normal operation resumes.
